des_perm_pipe: RTL and testbench
================================

# des_perm_pipe

Parametrised, pipelined DES bit-permutation engine. It applies either the DES initial permutation (IP) or the final/inverse permutation (FP = IP⁻¹) to a 64-bit block, selected per transaction. Each stage uses valid/ready handshaking and an elastic register pipeline, and a sideband tag travels with each block. It sits at the entry (IP) and exit (FP) of the pipelined DES round datapath, and replaces the separate combinational permutation modules with one shared, back-pressurable block.

## Interface
- STAGES, 2, number of register stages, legal 1..4
- TAG_W, 4, sideband tag width, legal 1..16
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; clears all stage valids
- in_valid  in  1  input block valid
- in_ready  out  1  block accepted when in_valid && in_ready
- in_mode  in  1  0 = IP, 1 = FP
- in_data  in  64  input block
- in_tag  in  TAG_W  sideband, passed unchanged
- out_valid  out  1  output block valid
- out_ready  in  1  consumer ready
- out_data  out  64  permuted block
- out_tag  out  TAG_W  tag of out_data
- out_mode  out  1  mode used for out_data
- occupancy  out  3  number of valid stages, 0..STAGES

Clock and reset are fixed as stated: one clock, with an asynchronous, active-high reset.

## Operation
- **FP mapping.** For i = 8r+c (r, c in 0..7): out[i] = in[(c even ? 32 : 0) + 8·(c>>1) + 7 − r].
  - Examples: out[0]=in[39], out[1]=in[7], out[8]=in[38], out[63]=in[24].
- **IP mapping.** IP is the exact inverse of FP: if FP maps in[j]→out[i], then IP maps in[i]→out[j].
- **Where the permutation happens.** The permutation is applied combinationally in front of stage 0 using in_mode. Later stages only carry {data, tag, mode, valid}.
- **Pipeline.** Stages 0..STAGES−1. Stage STAGES−1 drives the out_* ports.
- **Stage advance rule.**
  - Stage k loads when it is empty, or when its content is leaving this cycle.
  - Stage k's content leaves when it is the last stage and out_ready is high, or when stage k+1 loads.
  - Bubbles collapse: an empty stage always accepts from upstream.
- **in_ready** = stage 0 loads this cycle. This is a combinational path from out_ready, by design.
- **occupancy** = popcount of stage valids, registered together with the valids.
- **flush.** On the next edge all valids, and occupancy, become 0.
  - flush has priority over any load.
  - A block presented with in_valid during flush is discarded. in_ready still reflects the no-flush computation, so the producer must not count that transfer.
- **Data hold.** Stage data registers update only when the stage loads. out_data is held stable while out_valid && !out_ready.
- **Reset** (asynchronous, immediate): all valids = 0, out_valid = 0, occupancy = 0, out_data = 0, out_tag = 0, out_mode = 0.
  - in_ready reads 1 during and after reset, but the first transfer counts only at the first edge after rst deasserts.
  - Reset mid-stream drops all in-flight blocks.

## Timing
- **Latency.** A block accepted at edge N presents out_valid=1 after edge N+STAGES−1, i.e. it is visible in the cycle following the STAGES-th edge after acceptance begins counting. For STAGES=1 it is visible right after the accept edge.
- **Throughput.** 1 block per cycle when out_ready is held high. No bubbles are inserted.
- **Full condition.** occupancy == STAGES and out_ready == 0 forces in_ready = 0.
- **Simultaneous accept and output.** When full and out_ready=1, in_ready=1: one block leaves and one enters on the same edge, and occupancy is unchanged.
- **Ordering.** Blocks emerge strictly in acceptance order. Tag and mode stay aligned with their data.

## Test plan
- **Single-bit FP, IP and round trip** (STAGES=2, out_ready=1):
  - in_mode=1, in_data=64'h0000_0080_0000_0000 → out_data=64'h0000_0000_0000_0001 two edges later.
  - in_mode=0, in_data=64'h1 → out_data=64'h0000_0080_0000_0000.
  - in_mode=1, in_data=64'h80 → out_data=64'h2.
- **Exhaustive mapping:** for each of the 64 one-hot inputs, in both modes, check against the formula. Then feed each FP output back in IP mode and require the original value.
- **Backpressure:**
  - Stream 6 blocks with tags 0..5 while out_ready=0 → in_ready drops after 2 accepts, and occupancy=2.
  - Release out_ready → all 6 tags emerge in order, with no loss or duplication and out_data stable while stalled.
- **Full simultaneous exchange:** with occupancy=2, hold in_valid=1 and out_ready=1 for 10 cycles → 10 transfers on each side, and occupancy stays 2.
- **Flush:** with occupancy=2 and in_valid=1, assert flush for 1 cycle → next cycle out_valid=0 and occupancy=0. The flushed tags never appear at the output.
- **Reset mid-operation:** assert rst asynchronously between edges while occupancy=2 → out_valid, occupancy, out_data and out_tag go to 0 immediately. After release, a fresh block emerges with the correct latency.

Source files
------------

// File: rtl/des_perm_pipe_if.sv
// Handshake bundle for the DES IP/FP permutation pipeline.
// master = producer/consumer side, slave = the pipeline itself.
interface des_perm_pipe_if #(
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [63:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_mode;
    logic [2:0]       occupancy;

    modport master (
        output flush, in_valid, in_mode, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_mode, occupancy
    );

    modport slave (
        input  flush, in_valid, in_mode, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_mode, occupancy
    );
endinterface

// File: rtl/des_perm_pipe.sv
// Pipelined DES bit-permutation engine: IP (mode 0) or FP (mode 1) applied
// in front of stage 0, followed by an elastic valid/ready register chain
// carrying {data, tag, mode}. Bubbles collapse; ready ripples back
// combinationally from out_ready.
module des_perm_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    des_perm_pipe_if.slave bus
);

    logic [63:0]       data_p [STAGES];
    logic [TAG_W-1:0]  tag_p  [STAGES];
    logic [STAGES-1:0] mode_p;
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] vld_nxt;
    logic [STAGES-1:0] load;
    logic [2:0]        occ_q;
    logic [2:0]        occ_nxt;
    logic [63:0]       perm_in;

    // FP: out bit {r,c} takes input bit {~c[0], c[2:1], ~r}.
    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  i6;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            i6    = 6'(i);
            y[i]  = x[{~i6[0], i6[2:1], ~i6[5:3]}];
        end
        return y;
    endfunction

    // IP is the scatter form of the same index map, hence the exact inverse.
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  i6;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            i6 = 6'(i);
            y[{~i6[0], i6[2:1], ~i6[5:3]}] = x[i];
        end
        return y;
    endfunction

    assign perm_in = bus.in_mode ? perm_fp(bus.in_data) : perm_ip(bus.in_data);

    // Load enables ripple back from out_ready; next valids and their popcount.
    always_comb begin
        logic dl;
        load    = '0;
        vld_nxt = vld_p;
        occ_nxt = '0;
        dl      = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = ~vld_p[k] | dl;
            dl      = load[k];
        end
        if (load[0]) vld_nxt[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) vld_nxt[k] = vld_p[k-1];
        end
        if (bus.flush) vld_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_nxt = occ_nxt + 3'(vld_nxt[k]);
        end
    end

    // Stage valids and occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            occ_q <= '0;
        end else begin
            vld_p <= vld_nxt;
            occ_q <= occ_nxt;
        end
    end

    // Payload registers: capture only on a real load, frozen otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                data_p[k] <= '0;
                tag_p[k]  <= '0;
            end
            mode_p <= '0;
        end else if (!bus.flush) begin
            // stage 0: permuted input
            if (load[0] && bus.in_valid) begin
                data_p[0] <= perm_in;
                tag_p[0]  <= bus.in_tag;
                mode_p[0] <= bus.in_mode;
            end
            // stages 1..STAGES-1: plain carry
            for (int k = 1; k < STAGES; k++) begin
                if (load[k] && vld_p[k-1]) begin
                    data_p[k] <= data_p[k-1];
                    tag_p[k]  <= tag_p[k-1];
                    mode_p[k] <= mode_p[k-1];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld_p[STAGES-1];
    assign bus.out_data  = data_p[STAGES-1];
    assign bus.out_tag   = tag_p[STAGES-1];
    assign bus.out_mode  = mode_p[STAGES-1];
    assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: directed cases plus randomized traffic checked
// against a queue-based reference model of the permutation pipeline.
module tb_des_perm_pipe;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        logic             m;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    item_t q[$];
    item_t mon_it;

    des_perm_pipe_if #(.TAG_W(TAG_W)) bus();

    des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: FP output bit 8r+c comes from input bit (c even ? 32 : 0) + 8*(c/2) + 7 - r.
    function automatic int fp_src(input int i);
        int r, c;
        r = i / 8;
        c = i % 8;
        return ((c % 2 == 0) ? 32 : 0) + 8 * (c / 2) + 7 - r;
    endfunction

    function automatic logic [63:0] fp_ref(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[fp_src(i)];
        return y;
    endfunction

    // IP as the inverse of FP: find the FP output position each bit feeds.
    function automatic logic [63:0] ip_ref(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 64; j++)
            for (int i = 0; i < 64; i++)
                if (fp_src(i) == j) y[j] = x[i];
        return y;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                chk("out_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    mon_it = q.pop_front();
                    chk("out_data", bus.out_data, mon_it.d);
                    chk("out_tag", 64'(bus.out_tag), 64'(mon_it.t));
                    chk("out_mode", 64'(bus.out_mode), 64'(mon_it.m));
                end
            end
            if (bus.flush) begin
                q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                mon_it.d = bus.in_mode ? fp_ref(bus.in_data) : ip_ref(bus.in_data);
                mon_it.t = bus.in_tag;
                mon_it.m = bus.in_mode;
                q.push_back(mon_it);
            end
        end
    end

    task automatic push(input logic m, input logic [63:0] d, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_data  = d;
        bus.in_tag   = t;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic single(input logic m, input logic [63:0] d, input logic [63:0] e,
                          input logic [TAG_W-1:0] t);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.in_tag    = t;
        chk("single_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int s = 1; s < STAGES; s++) begin
            chk("lat_early", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_data", bus.out_data, e);
        chk("lat_tag", 64'(bus.out_tag), 64'(t));
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((bus.occupancy != 0 || bus.out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_occ", 64'(bus.occupancy), 64'd0);
        chk("drain_model", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int         acc, t, ni, no, n0;
        logic       took;
        logic [63:0] one;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_occ", 64'(bus.occupancy), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // Single-bit directed vectors
        single(1'b1, 64'h0000_0080_0000_0000, 64'h0000_0000_0000_0001, 4'h1);
        single(1'b0, 64'h0000_0000_0000_0001, 64'h0000_0080_0000_0000, 4'h2);
        single(1'b1, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0002, 4'h3);
        drain();

        // Exhaustive one-hot mapping in both modes (checked by the scoreboard)
        for (int m = 1; m >= 0; m--)
            for (int i = 0; i < 64; i++)
                push(1'(m), 64'd1 << i, 4'(i));
        drain();

        // Round trip: FP result fed back through IP must restore the bit
        for (int i = 0; i < 64; i++) begin
            one = 64'd1 << i;
            single(1'b0, fp_ref(one), one, 4'(i));
        end
        drain();

        // Backpressure: 6 tagged blocks against a stalled consumer
        n0 = n_out;
        bus.out_ready = 1'b0;
        acc = 0;
        t   = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_data  = {$urandom(), $urandom()};
        bus.in_tag   = 4'(t);
        repeat (8) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                t++;
                bus.in_data = {$urandom(), $urandom()};
                bus.in_tag  = 4'(t);
            end
            if (bus.out_valid && q.size() != 0)
                chk("stall_data", bus.out_data, q[0].d);
        end
        chk("bp_accepts", 64'(acc), 64'd2);
        chk("bp_occ", 64'(bus.occupancy), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (t < 6) begin
            push(1'b1, {$urandom(), $urandom()}, 4'(t));
            t++;
        end
        drain();
        chk("bp_count", 64'(n_out - n0), 64'd6);

        // Full simultaneous exchange
        bus.out_ready = 1'b0;
        push(1'b0, {$urandom(), $urandom()}, 4'hA);
        push(1'b1, {$urandom(), $urandom()}, 4'hB);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        ni = 0;
        no = 0;
        repeat (10) begin
            bus.in_mode = 1'($urandom());
            bus.in_data = {$urandom(), $urandom()};
            bus.in_tag  = 4'($urandom());
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) ni++;
            if (bus.out_valid && bus.out_ready) no++;
            @(posedge clk);
            #1;
            chk("xchg_occ", 64'(bus.occupancy), 64'd2);
        end
        bus.in_valid = 1'b0;
        chk("xchg_in", 64'(ni), 64'd10);
        chk("xchg_out", 64'(no), 64'd10);
        drain();

        // Flush with a full pipe and a pending input
        bus.out_ready = 1'b0;
        push(1'b1, {$urandom(), $urandom()}, 4'h5);
        push(1'b0, {$urandom(), $urandom()}, 4'h6);
        bus.in_valid = 1'b1;
        bus.in_tag   = 4'h7;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        n0 = n_out;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_no_out", 64'(n_out), 64'(n0));

        // Asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        push(1'b1, 64'hDEAD_BEEF_0123_4567, 4'h9);
        push(1'b0, 64'hFEDC_BA98_7654_3210, 4'hC);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_occ", 64'(bus.occupancy), 64'd0);
        chk("arst_data", bus.out_data, 64'd0);
        chk("arst_tag", 64'(bus.out_tag), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        single(1'b1, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0002, 4'hE);
        drain();

        // Randomized traffic with occasional flush
        repeat (400) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(2) != 0);
            bus.in_mode   = 1'($urandom());
            bus.in_data   = {$urandom(), $urandom()};
            bus.in_tag    = 4'($urandom());
            bus.flush     = ($urandom_range(49) == 0);
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
